// File: rtl/tx_framer.sv
// tx_framer: GMII transmit framer. Emits preamble, SFD, queued payload, zero pad, CRC-32 FCS, then the inter-frame gap.
// Latency: the first 0x55 appears one cycle after frame_ready is seen in IDLE. Payload byte 0 directly follows the SFD.
// Backpressure: the wire is never stalled. If the queue runs dry mid-frame, the frame is aborted with an inverted FCS and an underrun pulse.
//
// Ports:
//   clk, reset_n           single clock, asynchronous active-low reset
//   frame_ready            queue holds at least one complete frame
//   rd_o / data_i / empty_i  queue read strobe, {last, byte} word one cycle after rd_o, queue empty flag
//   tx_data / tx_ctrl      GMII TXD / TX_EN, both registered
//   underrun               one-cycle pulse when a mid-frame read finds the queue empty
//   busy                   high from the first preamble byte through the last IFG cycle
module tx_framer #(
  parameter int P_MIN_FRAME = 60,
  parameter int P_IFG       = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_ready,
  output logic       rd_o,
  input  logic [8:0] data_i,
  input  logic       empty_i,
  output logic [7:0] tx_data,
  output logic       tx_ctrl,
  output logic       underrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } state_t;

  localparam int          IW        = (P_IFG > 1) ? $clog2(P_IFG) : 1;
  localparam logic [IW-1:0] IFG_LAST = IW'(P_IFG - 1);
  localparam logic [10:0] MIN_LEN   = 11'(P_MIN_FRAME);
  localparam logic [10:0] CNT_MAX   = 11'h7FF;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
  localparam logic [7:0]  PRE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE  = 8'hD5;

  // Reflected CRC-32, one byte per call, data consumed LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] byte_in);
    logic [31:0] r;
    r = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ byte_in[i]) begin
        r = (r >> 1) ^ CRC_POLY;
      end else begin
        r = r >> 1;
      end
    end
    return r;
  endfunction

  state_t        state_q, state_nx;
  logic [10:0]   byte_cnt_q, byte_cnt_nx;  // payload + pad bytes loaded so far
  logic [2:0]    sub_q, sub_nx;            // preamble index, then FCS byte index
  logic [IW-1:0] ifg_q, ifg_nx;
  logic [31:0]   crc_q, crc_nx;
  logic          uflag_q, uflag_nx;        // this frame was cut short by an underrun
  logic          rd_pend_q;                // a read was issued last cycle, so data_i is valid now
  logic [7:0]    data_nx;
  logic          ctrl_nx;
  logic          urun_nx;
  logic          start;
  logic [31:0]   fcs_word;
  logic [10:0]   cnt_inc;

  // An aborted frame sends the raw register, i.e. the bitwise inverse of a good FCS.
  assign fcs_word = uflag_q ? crc_q : ~crc_q;
  assign cnt_inc  = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_nx    = state_q;
    byte_cnt_nx = byte_cnt_q;
    sub_nx      = sub_q;
    ifg_nx      = ifg_q;
    crc_nx      = crc_q;
    uflag_nx    = uflag_q;
    data_nx     = tx_data;
    ctrl_nx     = tx_ctrl;
    urun_nx     = 1'b0;
    rd_o        = 1'b0;
    start       = 1'b0;

    case (state_q)
      IDLE: begin
        data_nx = 8'h00;
        ctrl_nx = 1'b0;
        start   = frame_ready;
      end

      PREAMBLE: begin
        if (sub_q == 3'd6) begin
          // The last preamble cycle issues the first read, so byte 0 is
          // available while the SFD is on the wire.
          data_nx  = SFD_BYTE;
          state_nx = SFD;
          if (empty_i) begin
            uflag_nx = 1'b1;
            urun_nx  = 1'b1;
          end else begin
            rd_o = 1'b1;
          end
        end else begin
          data_nx = PRE_BYTE;
          sub_nx  = sub_q + 3'd1;
        end
      end

      // The SFD, DATA and PAD states share one decision. A pending read
      // delivers a payload byte. Otherwise the payload is finished, so the
      // framer either pads or starts the FCS.
      SFD, DATA, PAD: begin
        if (rd_pend_q) begin
          data_nx     = data_i[7:0];
          crc_nx      = crc_byte(crc_q, data_i[7:0]);
          byte_cnt_nx = cnt_inc;
          state_nx    = DATA;
          // rd_o is gated by the last flag of the word arriving now. This
          // keeps the read count equal to the frame length.
          if (!data_i[8]) begin
            if (empty_i) begin
              uflag_nx = 1'b1;
              urun_nx  = 1'b1;
            end else begin
              rd_o = 1'b1;
            end
          end
        end else if (uflag_q || (byte_cnt_q >= MIN_LEN)) begin
          data_nx  = fcs_word[7:0];
          sub_nx   = 3'd1;
          state_nx = FCS;
        end else begin
          data_nx     = 8'h00;
          crc_nx      = crc_byte(crc_q, 8'h00);
          byte_cnt_nx = cnt_inc;
          state_nx    = PAD;
        end
      end

      FCS: begin
        if (sub_q == 3'd4) begin
          data_nx  = 8'h00;
          ctrl_nx  = 1'b0;
          ifg_nx   = '0;
          state_nx = IFG;
        end else begin
          data_nx = fcs_word[{sub_q[1:0], 3'b000} +: 8];
          sub_nx  = sub_q + 3'd1;
        end
      end

      IFG: begin
        data_nx = 8'h00;
        ctrl_nx = 1'b0;
        // The last gap cycle may launch the next preamble directly. This
        // gives exactly P_IFG idle cycles between back-to-back frames.
        if (ifg_q == IFG_LAST) begin
          state_nx = IDLE;
          start    = frame_ready;
        end else begin
          ifg_nx = ifg_q + IW'(1);
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    if (start) begin
      state_nx    = PREAMBLE;
      sub_nx      = 3'd0;
      byte_cnt_nx = 11'd0;
      crc_nx      = CRC_INIT;
      uflag_nx    = 1'b0;
      data_nx     = PRE_BYTE;
      ctrl_nx     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= 11'd0;
      sub_q      <= 3'd0;
      ifg_q      <= '0;
      crc_q      <= CRC_INIT;
      uflag_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      tx_data    <= 8'h00;
      tx_ctrl    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_nx;
      byte_cnt_q <= byte_cnt_nx;
      sub_q      <= sub_nx;
      ifg_q      <= ifg_nx;
      crc_q      <= crc_nx;
      uflag_q    <= uflag_nx;
      rd_pend_q  <= rd_o;
      tx_data    <= data_nx;
      tx_ctrl    <= ctrl_nx;
      underrun   <= urun_nx;
    end
  end

endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: bench for tx_framer. It uses a queue model, a wire monitor and a scoreboard of expected wire bytes.
// Latency: the queue model returns data one cycle after rd_o. The monitor samples on the falling edge.
// Backpressure: empty_i can be forced at a chosen read pointer to provoke an underrun.
module tb_tx_framer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Two instances: "a" uses the default minimum length, "b" uses a minimum of 9 for the CRC vector.
  logic       sel, fr_en, flush;
  logic [8:0] q_data = 9'd0;
  int         wr_ptr, empty_at;
  int         rd_ptr = 0;
  logic [8:0] mem [0:4095];
  logic       q_frame, q_empty, q_rd;

  logic       a_rd, a_ctrl, a_urun, a_busy;
  logic [7:0] a_data;
  logic       b_rd, b_ctrl, b_urun, b_busy;
  logic [7:0] b_data;

  assign q_frame = fr_en && (rd_ptr < wr_ptr);
  assign q_empty = (rd_ptr >= wr_ptr) || (rd_ptr >= empty_at);
  assign q_rd    = sel ? b_rd : a_rd;

  tx_framer #(.P_MIN_FRAME(60), .P_IFG(12)) dut (
    .clk(clk), .reset_n(rst_n), .frame_ready(!sel && q_frame), .rd_o(a_rd),
    .data_i(q_data), .empty_i(sel || q_empty), .tx_data(a_data), .tx_ctrl(a_ctrl),
    .underrun(a_urun), .busy(a_busy)
  );

  tx_framer #(.P_MIN_FRAME(9), .P_IFG(12)) dut9 (
    .clk(clk), .reset_n(rst_n), .frame_ready(sel && q_frame), .rd_o(b_rd),
    .data_i(q_data), .empty_i(!sel || q_empty), .tx_data(b_data), .tx_ctrl(b_ctrl),
    .underrun(b_urun), .busy(b_busy)
  );

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (q_rd) begin
      q_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Wire monitor. It is the only writer of the capture state below.
  logic [7:0] m_data;
  logic       m_ctrl, m_rd, m_urun, m_busy;
  assign m_data = sel ? b_data : a_data;
  assign m_ctrl = sel ? b_ctrl : a_ctrl;
  assign m_rd   = sel ? b_rd   : a_rd;
  assign m_urun = sel ? b_urun : a_urun;
  assign m_busy = sel ? b_busy : a_busy;

  logic [7:0] cap_mem [0:8191];
  int         len_mem [0:63];
  int cap_n = 0, run_len = 0, frames_done = 0, idle_cnt = 0, idle_busy = 0;
  int last_gap = 0, rd_cnt = 0, urun_cnt = 0;
  logic prev_ctrl = 1'b0;

  always @(negedge clk) begin
    if (m_ctrl) begin
      if (!prev_ctrl) last_gap = idle_cnt;
      cap_mem[cap_n] = m_data;
      cap_n++;
      run_len++;
      idle_cnt  = 0;
      idle_busy = 0;
    end else begin
      if (prev_ctrl) begin
        len_mem[frames_done] = run_len;
        frames_done++;
        run_len = 0;
      end
      idle_cnt++;
      if (m_busy) idle_busy++;
    end
    if (m_rd) rd_cnt++;
    if (m_urun) urun_cnt++;
    prev_ctrl = m_ctrl;
  end

  // Scoreboard. Expected wire bytes are pushed as frames are loaded and popped against captures.
  logic [7:0] exp_q [$];
  int cap_rd = 0;
  int n_checks = 0, n_pass = 0;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load an n-byte random frame. If cut >= 0, the queue will appear empty after cut reads.
  task automatic load_frame(input int n, input int minf, input int cut);
    logic [31:0] crc, fcs;
    logic [7:0]  b;
    int          sent;
    crc  = 32'hFFFFFFFF;
    sent = (cut >= 0 && cut < n) ? cut : n;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      mem[wr_ptr] = {(i == n - 1), b};
      wr_ptr++;
      if (i < sent) begin
        exp_q.push_back(b);
        crc = crc_upd(crc, b);
      end
    end
    if (cut < 0) begin
      for (int i = n; i < minf; i++) begin
        exp_q.push_back(8'h00);
        crc = crc_upd(crc, 8'h00);
      end
    end
    fcs = (cut >= 0) ? crc : ~crc;
    for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0; fr_en = 1'b0; flush = 1'b0;
    wr_ptr = 0; empty_at = 32'h7FFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (a_data !== 8'h00) $display("FAIL reset_tx_data: got %0h need 0", a_data); else n_pass++;
    n_checks++; if (a_ctrl !== 1'b0) $display("FAIL reset_tx_ctrl: got %0b need 0", a_ctrl); else n_pass++;
    n_checks++; if (a_rd !== 1'b0) $display("FAIL reset_rd_o: got %0b need 0", a_rd); else n_pass++;
    n_checks++; if (a_urun !== 1'b0) $display("FAIL reset_underrun: got %0b need 0", a_urun); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %0b need 0", a_busy); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_crc_vector();
    string       s;
    logic [7:0]  fcs_ref [4];
    logic [7:0]  e, a;
    int f0, r0, t;
    s = "123456789";
    fcs_ref = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    sel = 1'b1; fr_en = 1'b1;
    tick();
    f0 = frames_done; r0 = rd_cnt; cap_rd = cap_n;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 9; i++) begin
      mem[wr_ptr] = {(i == 8), 8'(s[i])};
      wr_ptr++;
      exp_q.push_back(8'(s[i]));
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(fcs_ref[i]);
    t = 0;
    while (frames_done < f0 + 1 && t < 500) begin @(posedge clk); t++; end
    n_checks++; if (frames_done < f0 + 1) $display("FAIL crc_timeout: frames %0d need %0d", frames_done - f0, 1); else n_pass++;
    repeat (16) @(posedge clk);
    #1;
    n_checks++; if (len_mem[f0] !== 21) $display("FAIL crc_ctrl_len: got %0d need 21", len_mem[f0]); else n_pass++;
    n_checks++; if (rd_cnt - r0 !== 9) $display("FAIL crc_rd_count: got %0d need 9", rd_cnt - r0); else n_pass++;
    n_checks++; if (idle_busy !== 12) $display("FAIL crc_ifg: got %0d need 12", idle_busy); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = cap_mem[cap_rd]; cap_rd++;
      n_checks++; if (a !== e) $display("FAIL crc_byte %0d: got %0h need %0h", cap_rd - 1, a, e); else n_pass++;
    end
    sel = 1'b0;
    tick();
  endtask

  task automatic test_padding();
    logic [7:0] e, a;
    int f0, r0, t;
    cap_rd = cap_n; f0 = frames_done; r0 = rd_cnt;
    load_frame(14, 60, -1);
    t = 0;
    while (frames_done < f0 + 1 && t < 500) begin @(posedge clk); t++; end
    n_checks++; if (frames_done < f0 + 1) $display("FAIL pad_timeout: frames %0d need 1", frames_done - f0); else n_pass++;
    repeat (16) @(posedge clk);
    #1;
    n_checks++; if (len_mem[f0] !== 72) $display("FAIL pad_ctrl_len: got %0d need 72", len_mem[f0]); else n_pass++;
    n_checks++; if (rd_cnt - r0 !== 14) $display("FAIL pad_rd_count: got %0d need 14", rd_cnt - r0); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL pad_busy_end: got %0b need 0", a_busy); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = cap_mem[cap_rd]; cap_rd++;
      n_checks++; if (a !== e) $display("FAIL pad_byte %0d: got %0h need %0h", cap_rd - 1, a, e); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, a;
    int f0, r0, t;
    cap_rd = cap_n; f0 = frames_done; r0 = rd_cnt;
    load_frame(64, 60, -1);
    load_frame(64, 60, -1);
    t = 0;
    while (frames_done < f0 + 2 && t < 1000) begin @(posedge clk); t++; end
    n_checks++; if (frames_done < f0 + 2) $display("FAIL b2b_timeout: frames %0d need 2", frames_done - f0); else n_pass++;
    repeat (16) @(posedge clk);
    #1;
    n_checks++; if (len_mem[f0] !== 76) $display("FAIL b2b_len1: got %0d need 76", len_mem[f0]); else n_pass++;
    n_checks++; if (len_mem[f0 + 1] !== 76) $display("FAIL b2b_len2: got %0d need 76", len_mem[f0 + 1]); else n_pass++;
    n_checks++; if (last_gap !== 12) $display("FAIL b2b_gap: got %0d need 12", last_gap); else n_pass++;
    n_checks++; if (rd_cnt - r0 !== 128) $display("FAIL b2b_rd_count: got %0d need 128", rd_cnt - r0); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = cap_mem[cap_rd]; cap_rd++;
      n_checks++; if (a !== e) $display("FAIL b2b_byte %0d: got %0h need %0h", cap_rd - 1, a, e); else n_pass++;
    end
  endtask

  task automatic test_max_len();
    logic [7:0] e, a;
    int f0, r0, t;
    cap_rd = cap_n; f0 = frames_done; r0 = rd_cnt;
    load_frame(1518, 60, -1);
    t = 0;
    while (frames_done < f0 + 1 && t < 3000) begin @(posedge clk); t++; end
    n_checks++; if (frames_done < f0 + 1) $display("FAIL max_timeout: frames %0d need 1", frames_done - f0); else n_pass++;
    repeat (16) @(posedge clk);
    #1;
    n_checks++; if (len_mem[f0] !== 1530) $display("FAIL max_ctrl_len: got %0d need 1530", len_mem[f0]); else n_pass++;
    n_checks++; if (rd_cnt - r0 !== 1518) $display("FAIL max_rd_count: got %0d need 1518", rd_cnt - r0); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = cap_mem[cap_rd]; cap_rd++;
      n_checks++; if (a !== e) $display("FAIL max_byte %0d: got %0h need %0h", cap_rd - 1, a, e); else n_pass++;
    end
  endtask

  task automatic test_underrun();
    logic [7:0] e, a;
    int f0, r0, u0, t;
    cap_rd = cap_n; f0 = frames_done; r0 = rd_cnt; u0 = urun_cnt;
    empty_at = wr_ptr + 30;
    load_frame(100, 60, 30);
    t = 0;
    while (!a_ctrl && t < 100) begin @(posedge clk); t++; end
    #1;
    fr_en = 1'b0;   // leftover bytes must not start another frame
    t = 0;
    while (frames_done < f0 + 1 && t < 500) begin @(posedge clk); t++; end
    n_checks++; if (frames_done < f0 + 1) $display("FAIL urun_timeout: frames %0d need 1", frames_done - f0); else n_pass++;
    repeat (16) @(posedge clk);
    #1;
    n_checks++; if (urun_cnt - u0 !== 1) $display("FAIL urun_pulses: got %0d need 1", urun_cnt - u0); else n_pass++;
    n_checks++; if (len_mem[f0] !== 42) $display("FAIL urun_ctrl_len: got %0d need 42", len_mem[f0]); else n_pass++;
    n_checks++; if (rd_cnt - r0 !== 30) $display("FAIL urun_rd_count: got %0d need 30", rd_cnt - r0); else n_pass++;
    n_checks++; if (idle_busy !== 12) $display("FAIL urun_ifg: got %0d need 12", idle_busy); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = cap_mem[cap_rd]; cap_rd++;
      n_checks++; if (a !== e) $display("FAIL urun_byte %0d: got %0h need %0h", cap_rd - 1, a, e); else n_pass++;
    end
    empty_at = 32'h7FFFFFFF;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fr_en = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] e, a;
    int c0, f0, r0, t;
    c0 = cap_n;
    load_frame(40, 60, -1);
    t = 0;
    while (cap_n < c0 + 18 && t < 200) begin @(posedge clk); t++; end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_ctrl !== 1'b0) $display("FAIL rstmid_tx_ctrl: got %0b need 0", a_ctrl); else n_pass++;
    n_checks++; if (a_rd !== 1'b0) $display("FAIL rstmid_rd_o: got %0b need 0", a_rd); else n_pass++;
    n_checks++; if (a_data !== 8'h00) $display("FAIL rstmid_tx_data: got %0h need 0", a_data); else n_pass++;
    r0 = rd_cnt;
    exp_q.delete();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    n_checks++; if (rd_cnt !== r0) $display("FAIL rstmid_no_reads: got %0d need %0d", rd_cnt, r0); else n_pass++;
    rst_n = 1'b1;
    tick();
    cap_rd = cap_n; f0 = frames_done;
    load_frame(20, 60, -1);
    t = 0;
    while (frames_done < f0 + 1 && t < 500) begin @(posedge clk); t++; end
    n_checks++; if (frames_done < f0 + 1) $display("FAIL rstmid_timeout: frames %0d need 1", frames_done - f0); else n_pass++;
    repeat (16) @(posedge clk);
    #1;
    n_checks++; if (len_mem[f0] !== 72) $display("FAIL rstmid_ctrl_len: got %0d need 72", len_mem[f0]); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = cap_mem[cap_rd]; cap_rd++;
      n_checks++; if (a !== e) $display("FAIL rstmid_byte %0d: got %0h need %0h", cap_rd - 1, a, e); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_crc_vector();
    fr_en = 1'b1;
    test_padding();
    test_back_to_back();
    test_max_len();
    test_underrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
